ls_aont_engine: RTL and testbench
=================================

LS_AONT_ENGINE -- requirements
Module: ls_aont_engine

Interface
REQ-001 SHALL have parameter LSLEN, default 16: Latin-square order and symbols per block; must be a power of 2, ≥2.
REQ-002 SHALL have parameter LSLENLOG, default 4: symbol width, log2(LSLEN).
REQ-003 SHALL have parameter NOOFBLOCKS, default 9: message blocks per packet, ≥1.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1: synchronous, active-high reset. The name is retained, but the polarity is active-high.
REQ-006 SHALL have port start, input, 1: a pulse that begins a packet; honoured only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: the engine accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, LSLENLOG: key symbol or message symbol.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: the sink accepts out_data.
REQ-012 SHALL have port out_data, output, LSLENLOG: transformed symbol.
REQ-013 SHALL have port out_last, output, 1: marks the final tail symbol.
REQ-014 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-015 SHALL have port err, output, 1: one-cycle pulse when the key is not a permutation.

Function
REQ-016 SHALL implement FSM states IDLE, KEY, CHECK, DATA, TAIL.
- IDLE→KEY on start.
- KEY→CHECK after LSLEN accepted symbols.
- CHECK→DATA if the key is valid, else →IDLE with err.
- DATA→TAIL after NOOFBLOCKS*LSLEN accepted symbols.
- TAIL→IDLE on the handshake of the out_last symbol.
REQ-017 KEY SHALL store the accepted symbols as key[0..LSLEN-1] in arrival order, with in_ready=1, and SHALL set seen[in_data].
REQ-018 CHECK SHALL last exactly one cycle, with in_ready=0; the key is valid iff seen is all-ones.
REQ-019 Latin-square entry L[r][j] SHALL equal key[(r+j) mod LSLEN], computed on the fly; no full square is stored.
REQ-020 In DATA, symbol j of block b SHALL produce c = m XOR L[b mod LSLEN][j], and acc[j] SHALL be updated to acc[j] XOR c.
REQ-021 In TAIL, the engine SHALL emit LSLEN symbols t[j] = key[j] XOR acc[j], for j = 0..LSLEN-1, with out_last set on j = LSLEN-1.
REQ-022 Output SHALL be a single register stage: out_valid rises the cycle after input acceptance (latency 1).
REQ-023 In DATA, in_ready SHALL equal (!out_valid || out_ready); no symbol is dropped or duplicated.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-025 Index counters SHALL wrap modulo LSLEN; the block counter runs to NOOFBLOCKS-1 and does not wrap mid-packet.
REQ-026 start SHALL be ignored when busy=1; in_valid in IDLE or CHECK SHALL be ignored.
REQ-027 A simultaneous start and rstn SHALL give reset priority.

Reset
REQ-028 On rstn=1, state SHALL be IDLE and all counters, acc, and seen SHALL be 0.
REQ-029 On rstn=1, outputs SHALL be in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0.
REQ-030 Reset mid-packet SHALL abort it and discard any pending output without handshake; the key register need not be cleared.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and a symbol typedef sized by LSLENLOG.
REQ-032 The Latin-square row/column lookup SHALL be one sub-module, ls_row_lookup: combinational, key array plus r and j in, symbol out, parametrised by LSLEN.

Verification
(All with LSLEN=4, LSLENLOG=2, NOOFBLOCKS=2, key [1,3,0,2].)
REQ-033 Nominal packet SHALL work end to end.
- Stimulus: message [0,0,0,0],[1,1,1,1].
- Required outputs: [1,3,0,2], [2,1,3,0], then tail [2,1,3,0] with out_last on the final 0.
REQ-034 A bad key SHALL be rejected.
- Stimulus: key [1,1,0,2].
- Required response: err pulses in CHECK (one cycle after the 4th key symbol), then IDLE, with no out_valid.
REQ-035 Backpressure SHALL not corrupt data.
- Stimulus: nominal packet with out_ready toggling every 2 cycles.
- Required response: identical output sequence; out_data stable while stalled; in_ready low whenever out_valid=1 and out_ready=0.
REQ-036 Reset mid-stream SHALL abort and allow clean restart.
- Stimulus: rstn asserted after the 5th message symbol.
- Required response: next cycle all outputs 0 and busy=0; a fresh nominal packet then reproduces REQ-033 exactly.
REQ-037 A restart while busy SHALL be ignored.
- Stimulus: start pulsed during DATA.
- Required response: no effect; the output sequence matches REQ-033.

Source files
------------

// File: rtl/ls_aont_engine_pkg.sv
// Shared types for the Latin-square all-or-nothing transform engine:
// FSM state encoding and the default-width symbol type.
package ls_aont_engine_pkg;

   localparam int LSLENLOG_DEF = 4;

   typedef logic [LSLENLOG_DEF-1:0] sym_t;

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      CHECK,
      DATA,
      TAIL
   } state_t;

endpackage

// File: rtl/ls_aont_engine_row_lookup.sv
// Combinational Latin-square lookup: L[r][j] = key[(r + j) mod LSLEN].
// The square is never stored; each entry is derived from the key row.
module ls_row_lookup
   import ls_aont_engine_pkg::*;
#(
   parameter int LSLEN    = 16,
   parameter int LSLENLOG = 4
) (
   input  logic [LSLEN-1:0][LSLENLOG-1:0] key,
   input  logic [LSLENLOG-1:0]            r,
   input  logic [LSLENLOG-1:0]            j,
   output logic [LSLENLOG-1:0]            sym
);

   logic [LSLENLOG-1:0] idx;

   // LSLEN is a power of two, so the truncated sum is already mod LSLEN
   assign idx = r + j;
   assign sym = key[idx];

endmodule

// File: rtl/ls_aont_engine.sv
// Latin-square AONT engine: loads and validates a permutation key, masks
// message blocks with rows of the square, then emits a key-masked checksum tail.
module ls_aont_engine
   import ls_aont_engine_pkg::*;
#(
   parameter int LSLEN      = 16,
   parameter int LSLENLOG   = 4,
   parameter int NOOFBLOCKS = 9
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LSLENLOG-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LSLENLOG-1:0] out_data,
   output logic                out_last,
   output logic                busy,
   output logic                err
);

   localparam int BW = (NOOFBLOCKS > 1) ? $clog2(NOOFBLOCKS) : 1;

   state_t state, state_nxt;

   logic [LSLEN-1:0][LSLENLOG-1:0] key_reg;
   logic [LSLEN-1:0][LSLENLOG-1:0] acc;
   logic [LSLEN-1:0]               seen;
   logic [LSLENLOG-1:0]            col;
   logic [LSLENLOG-1:0]            row;
   logic [BW-1:0]                  blk;
   logic [LSLENLOG-1:0]            lsym;
   logic [LSLENLOG-1:0]            cipher;
   logic                           key_acc;
   logic                           data_acc;
   logic                           tail_load;
   logic                           col_last;
   logic                           blk_last;

   ls_row_lookup #(
      .LSLEN    (LSLEN),
      .LSLENLOG (LSLENLOG)
   ) u_lookup (
      .key (key_reg),
      .r   (row),
      .j   (col),
      .sym (lsym)
   );

   assign col_last  = (col == LSLENLOG'(LSLEN - 1));
   assign blk_last  = (blk == BW'(NOOFBLOCKS - 1));
   assign cipher    = in_data ^ lsym;
   assign key_acc   = (state == KEY) && in_valid;
   assign data_acc  = (state == DATA) && in_valid && in_ready;
   // A tail symbol is loaded whenever the output slot frees up, until out_last is queued
   assign tail_load = (state == TAIL) && (!out_valid || out_ready) && !(out_valid && out_last);
   assign busy      = (state != IDLE);
   assign err       = (state == CHECK) && !(&seen);

   always_ff @(posedge clk) begin
      if (rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = KEY;
         end
         KEY: begin
            in_ready = 1'b1;
            if (in_valid && col_last) state_nxt = CHECK;
         end
         CHECK: begin
            state_nxt = (&seen) ? DATA : IDLE;
         end
         DATA: begin
            in_ready = !out_valid || out_ready;
            if (data_acc && col_last && blk_last) state_nxt = TAIL;
         end
         TAIL: begin
            if (out_valid && out_ready && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One column counter serves key loading, data columns and tail indexing
   always_ff @(posedge clk) begin
      if (rstn) begin
         col  <= '0;
         row  <= '0;
         blk  <= '0;
         acc  <= '0;
         seen <= '0;
      end else begin
         if (state == IDLE && start) begin
            col  <= '0;
            row  <= '0;
            blk  <= '0;
            acc  <= '0;
            seen <= '0;
         end
         if (key_acc) begin
            seen[in_data] <= 1'b1;
            col           <= col + 1'b1;
         end
         if (data_acc) begin
            acc[col] <= acc[col] ^ cipher;
            col      <= col + 1'b1;
            if (col_last) begin
               row <= row + 1'b1;
               blk <= blk_last ? '0 : blk + 1'b1;
            end
         end
         if (tail_load) begin
            col <= col + 1'b1;
         end
      end
   end

   // The key survives reset; it is always fully rewritten before use
   always_ff @(posedge clk) begin
      if (key_acc) begin
         key_reg[col] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (data_acc) begin
         out_valid <= 1'b1;
         out_data  <= cipher;
         out_last  <= 1'b0;
      end else if (tail_load) begin
         out_valid <= 1'b1;
         out_data  <= key_reg[col] ^ acc[col];
         out_last  <= col_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ls_aont_engine.sv
// Directed bench for ls_aont_engine with LSLEN=4, NOOFBLOCKS=2: a reference
// model fills a scoreboard that is drained against observed output handshakes.
module tb_ls_aont_engine;

   localparam int L    = 4;
   localparam int LW   = 2;
   localparam int NB   = 2;
   localparam int NOUT = NB * L + L;

   logic          clk       = 1'b0;
   logic          rstn      = 1'b1;
   logic          start     = 1'b0;
   logic          in_valid  = 1'b0;
   logic [LW-1:0] in_data   = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [LW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          err;

   int            total = 0;
   int            bad   = 0;
   logic [2:0]    obs[$];
   logic [2:0]    expq[$];
   int            vcycles    = 0;
   int            stall_viol = 0;
   logic          held       = 1'b0;
   logic [2:0]    held_val   = '0;
   logic          bp_mode    = 1'b0;
   int            ph         = 0;
   logic [LW-1:0] key_v[L];
   logic [LW-1:0] msg_v[NB*L];
   int            v0;

   ls_aont_engine #(
      .LSLEN      (L),
      .LSLENLOG   (LW),
      .NOOFBLOCKS (NB)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Sink: always ready, or two cycles ready / two cycles stalled in backpressure mode
   always begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
         ph++;
         out_ready = (((ph / 2) % 2) == 0) ? 1'b1 : 1'b0;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Records every output handshake and any stall-rule violation
   always @(negedge clk) begin
      if (out_valid === 1'b1) vcycles++;
      if (held) begin
         if (out_valid !== 1'b1 || {out_last, out_data} !== held_val) stall_viol++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b0 && in_ready !== 1'b0) stall_viol++;
      if (out_valid === 1'b1 && out_ready === 1'b1) obs.push_back({out_last, out_data});
      held     = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_val = {out_last, out_data};
   end

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic applyStimulus(input logic [LW-1:0] d);
      logic took;
      int   n;
      took     = 1'b0;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!took && n < 50) begin
         @(negedge clk);
         took = (in_ready === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      checkOutput("in_handshake", 8'(took), 8'd1);
   endtask

   task automatic pushModel(input int upto);
      logic [LW-1:0] acc_m[L];
      logic [LW-1:0] c;
      logic [LW-1:0] t;
      logic          lst;
      int            k;
      k = 0;
      for (int j = 0; j < L; j++) acc_m[j] = '0;
      for (int b = 0; b < NB; b++) begin
         for (int j = 0; j < L; j++) begin
            c        = msg_v[b*L + j] ^ key_v[((b % L) + j) % L];
            acc_m[j] = acc_m[j] ^ c;
            if (k < upto) expq.push_back({1'b0, c});
            k++;
         end
      end
      for (int j = 0; j < L; j++) begin
         t   = key_v[j] ^ acc_m[j];
         lst = (j == L - 1) ? 1'b1 : 1'b0;
         if (k < upto) expq.push_back({lst, t});
         k++;
      end
   endtask

   task automatic drain(input int n, input bit chk_idle);
      int         k;
      logic [2:0] o;
      logic [2:0] e;
      k = 0;
      while (obs.size() < n && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      checkOutput("out_count", 8'(obs.size()), 8'(n));
      for (int i = 0; i < n; i++) begin
         if (obs.size() > 0) o = obs.pop_front();
         else o = 3'bxxx;
         if (expq.size() > 0) e = expq.pop_front();
         else e = 3'bxxx;
         checkOutput("out_sym", {5'd0, o}, {5'd0, e});
      end
      if (chk_idle) checkOutput("busy_after_tail", 8'(busy), 8'd0);
      obs.delete();
      expq.delete();
   endtask

   task automatic sendPacket(input int nmsg, input int restart_at, input bit chk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (chk) checkOutput("busy_in_key", 8'(busy), 8'd1);
      for (int i = 0; i < L; i++) applyStimulus(key_v[i]);
      if (chk) begin
         checkOutput("check_in_ready", 8'(in_ready), 8'd0);
         checkOutput("check_err", 8'(err), 8'd0);
      end
      for (int i = 0; i < nmsg; i++) begin
         if (i == restart_at) start = 1'b1;
         applyStimulus(msg_v[i]);
         start = 1'b0;
      end
   endtask

   initial begin
      key_v = '{2'd1, 2'd3, 2'd0, 2'd2};
      msg_v = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 8'(in_ready), 8'd0);
      checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
      checkOutput("rst_out_data", 8'(out_data), 8'd0);
      checkOutput("rst_out_last", 8'(out_last), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      checkOutput("rst_err", 8'(err), 8'd0);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idle_busy", 8'(busy), 8'd0);

      // Nominal packet
      sendPacket(NB * L, -1, 1'b1);
      pushModel(NOUT);
      drain(NOUT, 1'b1);

      // Key with a repeated symbol is rejected
      key_v = '{2'd1, 2'd1, 2'd0, 2'd2};
      v0 = vcycles;
      sendPacket(0, -1, 1'b0);
      checkOutput("bad_err_pulse", 8'(err), 8'd1);
      checkOutput("bad_busy_check", 8'(busy), 8'd1);
      @(posedge clk);
      #1;
      checkOutput("bad_err_clear", 8'(err), 8'd0);
      checkOutput("bad_busy_idle", 8'(busy), 8'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bad_no_output", 8'(vcycles - v0), 8'd0);
      key_v = '{2'd1, 2'd3, 2'd0, 2'd2};

      // Backpressure with the sink toggling every two cycles
      bp_mode = 1'b1;
      sendPacket(NB * L, -1, 1'b0);
      pushModel(NOUT);
      drain(NOUT, 1'b1);
      bp_mode = 1'b0;
      checkOutput("stall_rules", 8'(stall_viol), 8'd0);

      // Reset after the fifth message symbol, then a clean packet
      sendPacket(5, -1, 1'b0);
      pushModel(5);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_in_ready", 8'(in_ready), 8'd0);
      checkOutput("abort_out_valid", 8'(out_valid), 8'd0);
      checkOutput("abort_out_data", 8'(out_data), 8'd0);
      checkOutput("abort_out_last", 8'(out_last), 8'd0);
      checkOutput("abort_busy", 8'(busy), 8'd0);
      checkOutput("abort_err", 8'(err), 8'd0);
      rstn = 1'b0;
      drain(5, 1'b0);
      sendPacket(NB * L, -1, 1'b0);
      pushModel(NOUT);
      drain(NOUT, 1'b1);

      // start pulsed mid-DATA must be ignored
      sendPacket(NB * L, 3, 1'b0);
      pushModel(NOUT);
      drain(NOUT, 1'b1);

      // Random message under the nominal key
      for (int i = 0; i < NB * L; i++) msg_v[i] = LW'($urandom_range(0, L - 1));
      sendPacket(NB * L, -1, 1'b0);
      pushModel(NOUT);
      drain(NOUT, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
